// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes a WIDTH-bit word over valid/ready
// and streams it one bit per clock on SOUT, back-to-back when fed.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   LSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SOUT,
  output logic             SOUT_VALID,
  output logic             WORD_DONE
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bits_left_q, bits_left_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             word_done_q, word_done_d;

  logic             din_ready;
  logic             accept;
  logic             first_bit;
  logic [WIDTH-1:0] shifted;
  logic             next_bit;

  assign din_ready = !sout_valid_q || (bits_left_q == '0);
  assign accept    = DIN_VALID && din_ready;

  assign first_bit = (LSB_FIRST != 0) ? DIN[0] : DIN[WIDTH-1];

  // shreg keeps the bit on SOUT at its output end
  assign shifted  = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
  assign next_bit = (LSB_FIRST != 0) ? shifted[0] : shifted[WIDTH-1];

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bits_left_d  = bits_left_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    if (accept) begin
      state_d      = SHIFT;
      shreg_d      = DIN;
      bits_left_d  = CW'(WIDTH - 1);
      sout_d       = first_bit;
      sout_valid_d = 1'b1;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (bits_left_q != '0) begin
            shreg_d     = shifted;
            bits_left_d = bits_left_q - CW'(1);
            sout_d      = next_bit;
          end else begin
            state_d      = IDLE;
            sout_valid_d = 1'b0;
            sout_d       = IDLE_LEVEL;
          end
        end
        default: begin
          sout_valid_d = 1'b0;
          sout_d       = IDLE_LEVEL;
        end
      endcase
    end
    word_done_d = sout_valid_d && (bits_left_d == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bits_left_q  <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bits_left_q  <= bits_left_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      word_done_q  <= word_done_d;
    end
  end

  assign DIN_READY  = din_ready;
  assign SOUT       = sout_q;
  assign SOUT_VALID = sout_valid_q;
  assign WORD_DONE  = word_done_q;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial pattern-detector FSMs. It accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per clock on SOUT. SOUT connects directly to the detector's single-bit IN input. Successive words stream back-to-back with no idle cycle when upstream keeps DIN_VALID high.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- LSB_FIRST, 0: 0 means DIN[WIDTH-1] is sent first; 1 means DIN[0] is sent first.
- IDLE_LEVEL, 1'b0: value driven on SOUT whenever SOUT_VALID=0.
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DIN  input  WIDTH  parallel word, sampled only on an accept edge.
- DIN_VALID  input  1  upstream has a word on DIN.
- DIN_READY  output  1  block can accept a word this cycle.
- SOUT  output  1  serial bit; feeds the detector's IN.
- SOUT_VALID  output  1  SOUT carries a data bit this cycle.
- WORD_DONE  output  1  high during the cycle the last bit of a word is on SOUT.

## Operation
- Internal state:
  - shreg[WIDTH-1:0] holds the word.
  - bits_left[$clog2(WIDTH)-1:0] counts the bits still to send after the one currently on SOUT.
  - Two-state FSM: IDLE (SOUT_VALID=0) and SHIFT (SOUT_VALID=1).
- All outputs except DIN_READY are registered. DIN_READY = !SOUT_VALID || (bits_left==0). It is combinational from registers only and never depends on DIN_VALID.
- Accept: DIN_VALID && DIN_READY at a rising edge. On that edge:
  - shreg <= DIN.
  - SOUT <= first bit (DIN[WIDTH-1], or DIN[0] if LSB_FIRST).
  - SOUT_VALID <= 1.
  - bits_left <= WIDTH-1.
  - FSM goes to SHIFT.
- SHIFT with bits_left>0 at an edge:
  - Shift shreg toward the output end.
  - SOUT <= next bit.
  - bits_left <= bits_left-1.
- SHIFT with bits_left==0 at an edge:
  - If an accept occurs, load the new word as above. The first new bit follows the last old bit with no gap.
  - Otherwise: SOUT_VALID <= 0, SOUT <= IDLE_LEVEL, FSM goes to IDLE.
- WORD_DONE = SOUT_VALID && bits_left==0, registered-equivalent: it is asserted for exactly one cycle per word.
- DIN_VALID while DIN_READY=0 is ignored. Upstream holds DIN stable until accepted. DIN changes while not ready have no effect.
- Reset (RST_N low, any time, including mid-word):
  - SOUT=IDLE_LEVEL, SOUT_VALID=0, WORD_DONE=0, DIN_READY=1.
  - shreg=0, bits_left=0, FSM=IDLE.
  - The partial word is discarded and no remaining bits are emitted after release.
- After RST_N rises, the first edge with DIN_VALID=1 accepts.

## Timing
- Latency: the word accepted at edge t puts bit 0 on SOUT in the cycle after edge t. Bit k is on SOUT after edge t+k. The last bit is on SOUT after edge t+WIDTH-1.
- Throughput: one word per WIDTH cycles with continuous DIN_VALID. DIN_READY pulses high for one cycle per word, coincident with WORD_DONE.
- Idle gap: if DIN_VALID is low in the WORD_DONE cycle, SOUT_VALID drops at the next edge. A later accept restarts with the 1-cycle load latency.
- Reset assertion takes effect immediately, without waiting for a clock. Deassertion is treated as synchronous to CLK by the surrounding system.

## Test plan
- Single word, WIDTH=8, MSB-first: accept 8'b11100011 at edge t.
  - Required: SOUT = 1,1,1,0,0,0,1,1 on cycles t+1..t+8, SOUT_VALID=1 on those cycles, WORD_DONE only on t+8.
  - Then SOUT=0 and SOUT_VALID=0 from t+9.
  - A chained detector asserts MATCH after the final 1.
- Back-to-back: DIN_VALID held high with 8'hA5 then 8'h3C.
  - Required: 16 consecutive valid bits 10100101 00111100 with no gap.
  - DIN_READY=1 only in the idle cycle and on the two WORD_DONE cycles.
- Backpressure: DIN_VALID high with 8'hFF during SHIFT, DIN changed to 8'h00 mid-word, then restored to 8'hFF before DIN_READY.
  - Required: no accept until bits_left==0.
  - The next word emitted is 8'hFF.
- LSB_FIRST=1: accept 8'b00000001.
  - Required: SOUT = 1,0,0,0,0,0,0,0.
- Reset mid-word: assert RST_N=0 asynchronously after 3 bits of 8'hF0.
  - Required: SOUT=0, SOUT_VALID=0 and DIN_READY=1 immediately.
  - No further bits after release.
  - A fresh 8'h81 after release serializes correctly.
- IDLE_LEVEL=1: with no accepts pending, SOUT=1 from reset onward and between words.
